// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared types and constants for the sensor polling sequencer
//
// Purpose : sequencer state encoding, transaction mode encodings, default
//           sensor address / configuration byte and a counter-width helper.
// Ports   : none (package).

package sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CFG     = 3'd1,
    ST_CFG_GAP = 3'd2,
    ST_READ    = 3'd3,
    ST_STORE   = 3'd4,
    ST_SLEEP   = 3'd5
  } seq_state_t;

  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

  localparam logic [6:0] DEF_SENSOR_ADDR = 7'h70;
  localparam logic [7:0] DEF_CFG_VAL     = 8'h92;

  localparam int SAMPLE_W = 8;

  // Bits needed to hold values 0..max_val inclusive (never less than 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - first-word fall-through sample FIFO
//
// Purpose : stores captured sensor samples until the consumer pops them.
// Ports   : clock, reset_n  - system clock, asynchronous active-low reset
//           push, wdata     - write strobe and data
//           pop             - read strobe (ignored while empty)
//           rdata           - head entry, forced to zero while empty
//           empty, full     - occupancy status

module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sensor_sequencer.sv
// rtl/sensor_sequencer.sv - configures an I2C sensor once, then polls it into a FIFO
//
// Purpose : drives an I2C master with one configuration write after enable,
//           then periodic reads; samples land in a sample FIFO.
// Ports   : clock, reset_n            - system clock, asynchronous active-low reset
//           enable                    - run request; dropping it idles after the current transaction
//           start, mode               - request level and direction (0 write, 1 read) to the master
//           sensor_address, write_val - target address and configuration byte
//           data_ready, read_val      - master completion flag and read data
//           rd_en, rd_data            - consumer pop strobe and FIFO head
//           empty, full               - FIFO status
//           overflow, timeout_err     - sticky error flags

module sensor_sequencer
  import sensor_pkg::*;
#(
  parameter logic [6:0] SENSOR_ADDR = DEF_SENSOR_ADDR,
  parameter logic [7:0] CFG_VAL     = DEF_CFG_VAL,
  parameter int         POLL_DIV    = 1000,
  parameter int         TIMEOUT     = 4000,
  parameter int         DEPTH       = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  output logic                start,
  output logic                mode,
  output logic [6:0]          sensor_address,
  output logic [7:0]          write_val,
  input  logic                data_ready,
  input  logic [SAMPLE_W-1:0] read_val,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                timeout_err
);

  localparam int PW = cnt_width(POLL_DIV);
  localparam int WW = cnt_width(TIMEOUT);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
  localparam logic [PW-1:0] POLL_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] WDOG_ONE  = {{(WW-1){1'b0}}, 1'b1};

  seq_state_t          state;
  seq_state_t          next_state;
  logic                data_ready_s;
  logic                data_ready_q;
  logic                dr_edge;
  logic [SAMPLE_W-1:0] sample;
  logic [PW-1:0]       poll_cnt;
  logic [WW-1:0]       wdog_cnt;
  logic                wdog_expired;
  logic                poll_done;
  logic                in_txn;
  logic                push;

  assign sensor_address = SENSOR_ADDR;

  // data_ready is registered before edge detection; read_val is held by the
  // master while data_ready stays high, so capturing one cycle later is safe.
  assign dr_edge      = data_ready_s & ~data_ready_q;
  assign in_txn       = (state == ST_CFG) || (state == ST_READ);
  assign wdog_expired = (wdog_cnt == WDOG_LAST);
  // >= rather than == covers a read that outlasted the poll period.
  assign poll_done    = (poll_cnt >= POLL_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    mode       = MODE_WRITE;
    write_val  = '0;
    push       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          next_state = ST_CFG;
        end
      end
      ST_CFG: begin
        start     = 1'b1;
        write_val = CFG_VAL;
        if (dr_edge) begin
          next_state = ST_CFG_GAP;
        end else if (wdog_expired) begin
          next_state = ST_IDLE;
        end
      end
      ST_CFG_GAP: begin
        next_state = enable ? ST_READ : ST_IDLE;
      end
      ST_READ: begin
        start = 1'b1;
        mode  = MODE_READ;
        if (dr_edge) begin
          next_state = ST_STORE;
        end else if (wdog_expired) begin
          next_state = ST_IDLE;
        end
      end
      ST_STORE: begin
        push       = !full || rd_en;
        next_state = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (!enable) begin
          next_state = ST_IDLE;
        end else if (poll_done) begin
          next_state = ST_READ;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_ready_s <= 1'b0;
      data_ready_q <= 1'b0;
      sample       <= '0;
      poll_cnt     <= '0;
      wdog_cnt     <= '0;
      overflow     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      data_ready_s <= data_ready;
      data_ready_q <= data_ready_s;

      if ((state == ST_READ) && dr_edge) begin
        sample <= read_val;
      end

      // Poll period is measured from each READ entry; saturate so a long
      // read cannot wrap the counter back below the threshold.
      if ((state != ST_READ) && (next_state == ST_READ)) begin
        poll_cnt <= '0;
      end else if (poll_cnt != '1) begin
        poll_cnt <= poll_cnt + POLL_ONE;
      end

      if (in_txn && (next_state == state)) begin
        wdog_cnt <= wdog_cnt + WDOG_ONE;
      end else begin
        wdog_cnt <= '0;
      end

      if ((state == ST_STORE) && full && !rd_en) begin
        overflow <= 1'b1;
      end

      if (in_txn && wdog_expired && !dr_edge) begin
        timeout_err <= 1'b1;
      end
    end
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (sample),
    .pop     (rd_en),
    .rdata   (rd_data),
    .empty   (empty),
    .full    (full)
  );

endmodule

// File: tb/tb_sensor_sequencer.sv
// tb/tb_sensor_sequencer.sv - self-checking bench with an I2C slave model and sample queue reference

module tb_sensor_sequencer;

  localparam int POLL_DIV = 200;
  localparam int TIMEOUT  = 500;
  localparam int DEPTH    = 4;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       start;
  logic       mode;
  logic [6:0] sensor_address;
  logic [7:0] write_val;
  logic       data_ready;
  logic [7:0] read_val;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // slave model state
  bit         slave_en  = 1'b1;
  int         force_dly = 0;
  bit         busy      = 1'b0;
  bit         cur_mode  = 1'b0;
  int         cnt       = 0;
  int         dly       = 0;
  logic [7:0] meas      = 8'hf0;
  int         wr_cnt    = 0;
  int         rd_cnt    = 0;
  logic [7:0] last_wval = 8'h00;
  logic [6:0] last_addr = 7'h00;
  int         dr_rise_cyc    = 0;
  int         last_start_cyc = 0;
  int         read_starts[$];

  // reference: samples the consumer should see, in order
  logic [7:0] model_q[$];
  bit         exp_ovf = 1'b0;

  sensor_sequencer #(
    .SENSOR_ADDR (7'h70),
    .CFG_VAL     (8'h92),
    .POLL_DIV    (POLL_DIV),
    .TIMEOUT     (TIMEOUT),
    .DEPTH       (DEPTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .start          (start),
    .mode           (mode),
    .sensor_address (sensor_address),
    .write_val      (write_val),
    .data_ready     (data_ready),
    .read_val       (read_val),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .empty          (empty),
    .full           (full),
    .overflow       (overflow),
    .timeout_err    (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: answers each start level after a random delay, holds data_ready
  // until start drops; a completed read feeds the reference queue.
  initial begin
    data_ready = 1'b0;
    read_val   = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        data_ready = 1'b0;
        busy       = 1'b0;
      end else if (start) begin
        if (!busy) begin
          busy           = 1'b1;
          cur_mode       = mode;
          cnt            = 0;
          last_start_cyc = cyc;
          dly            = (force_dly != 0) ? force_dly : int'($urandom_range(2, 8));
          if (mode) read_starts.push_back(cyc);
        end else if (slave_en && !data_ready) begin
          cnt++;
          if (cnt >= dly) begin
            data_ready = 1'b1;
            if (cur_mode) begin
              read_val    = meas;
              dr_rise_cyc = cyc;
            end else begin
              read_val  = 8'h00;
              wr_cnt++;
              last_wval = write_val;
              last_addr = sensor_address;
            end
          end
        end
      end else begin
        if (busy && data_ready && cur_mode) begin
          if (model_q.size() < DEPTH) model_q.push_back(meas);
          else exp_ovf = 1'b1;
          meas++;
          rd_cnt++;
        end
        data_ready = 1'b0;
        busy       = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int t;
    int hi;
    int wr_before;
    int rd_before;
    logic [7:0] pre_data;

    reset_n = 1'b0;
    enable  = 1'b0;
    rd_en   = 1'b0;
    repeat (3) @(negedge clock);

    // reset state
    check("rst_start", start, 0);
    check("rst_mode", mode, 0);
    check("rst_write_val", write_val, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_addr", sensor_address, 7'h70);

    // first configuration write then first read
    reset_n = 1'b1;
    enable  = 1'b1;
    for (t = 0; t < 500 && empty; t++) @(negedge clock);
    check("first_sample_wait", t < 500, 1);
    check("first_latency", cyc - dr_rise_cyc, 3);
    check("first_rd_data", rd_data, model_q[0]);
    check("first_rd_const", rd_data, 8'hf0);
    check("cfg_write_once", wr_cnt, 1);
    check("cfg_write_val", last_wval, 8'h92);
    check("cfg_addr", last_addr, 7'h70);

    // no consumer: fill the FIFO, then one more read overflows
    for (t = 0; t < 1500 && rd_cnt < 5; t++) @(negedge clock);
    check("fill_wait", t < 1500, 1);
    repeat (5) @(negedge clock);
    check("fill_full", full, model_q.size() == DEPTH);
    check("fill_overflow", overflow, exp_ovf);
    check("poll_gap_a", read_starts[2] - read_starts[1], POLL_DIV);
    check("poll_gap_b", read_starts[3] - read_starts[2], POLL_DIV);
    check("no_cfg_rewrite", wr_cnt, 1);
    enable = 1'b0;
    hi = 0;
    repeat (2 * POLL_DIV) begin
      @(negedge clock);
      if (start) hi++;
    end
    check("idle_after_disable", hi, 0);

    // drain with random gaps, checking order against the reference queue
    while (model_q.size() > 0) begin
      check("drain_data", rd_data, model_q[0]);
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      void'(model_q.pop_front());
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    check("drain_empty", empty, 1);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    check("pop_empty_ignored", empty, 1);
    check("pop_empty_data", rd_data, 0);
    check("pop_empty_full", full, 0);

    // enable dropped during READ: the read completes and is stored
    wr_before = wr_cnt;
    rd_before = rd_cnt;
    enable = 1'b1;
    for (t = 0; t < 300 && !(start === 1'b1 && mode === 1'b1); t++) @(negedge clock);
    check("read_wait", t < 300, 1);
    check("read_mode", mode, 1);
    check("rewrite_on_enable", wr_cnt, wr_before + 1);
    enable = 1'b0;
    for (t = 0; t < 100 && rd_cnt == rd_before; t++) @(negedge clock);
    check("late_read_done", t < 100, 1);
    repeat (4) @(negedge clock);
    check("late_read_pushed", empty, 0);
    check("late_read_data", rd_data, model_q[0]);
    hi = 0;
    repeat (2 * POLL_DIV) begin
      @(negedge clock);
      if (start) hi++;
    end
    check("late_read_idle", hi, 0);

    // unresponsive slave: configuration write times out
    slave_en = 1'b0;
    pre_data = rd_data;
    enable = 1'b1;
    for (t = 0; t < 20 && !start; t++) @(negedge clock);
    check("to_start_wait", t < 20, 1);
    repeat (10) @(negedge clock);
    enable = 1'b0;
    for (t = 0; t < 1000 && start; t++) @(negedge clock);
    check("to_drop_wait", t < 1000, 1);
    check("to_duration", cyc - last_start_cyc, TIMEOUT);
    check("to_flag", timeout_err, 1);
    repeat (50) @(negedge clock);
    check("to_idle_start", start, 0);
    check("to_no_push_data", rd_data, pre_data);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    void'(model_q.pop_front());
    check("to_no_push_empty", empty, 1);

    // reset pulsed mid-READ
    slave_en  = 1'b1;
    force_dly = 20;
    enable    = 1'b1;
    for (t = 0; t < 300 && !(start === 1'b1 && mode === 1'b1); t++) @(negedge clock);
    check("rr_read_wait", t < 300, 1);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rr_start_async", start, 0);
    check("rr_empty", empty, 1);
    check("rr_timeout_clr", timeout_err, 0);
    check("rr_overflow_clr", overflow, 0);
    model_q.delete();
    exp_ovf = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    force_dly = 0;
    wr_before = wr_cnt;
    for (t = 0; t < 500 && empty; t++) @(negedge clock);
    check("rr_sample_wait", t < 500, 1);
    check("rr_cfg_repeat", wr_cnt, wr_before + 1);
    check("rr_cfg_val", last_wval, 8'h92);
    check("rr_rd_data", rd_data, model_q[0]);
    check("rr_overflow", overflow, exp_ovf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_sequencer.md
SENSOR_SEQUENCER -- requirements
Module: sensor_sequencer

Interface
REQ-001 Parameter SENSOR_ADDR, default 7'h70, I2C address driven on sensor_address.
REQ-002 Parameter CFG_VAL, default 8'h92, configuration byte written once after reset/enable.
REQ-003 Parameter POLL_DIV, default 1000, clock cycles from one read start to the next read start.
REQ-004 Parameter TIMEOUT, default 4000, max cycles waiting for data_ready before abort.
REQ-005 Parameter DEPTH, default 4 (power of 2), sample FIFO depth.
REQ-006 clock  in  1  single system clock, all logic on posedge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  high = run sequence; low = finish current transaction, then idle.
REQ-009 start  out  1  level request to the I2C master; held until data_ready seen.
REQ-010 mode  out  1  0 = write transaction, 1 = read transaction.
REQ-011 sensor_address  out  7  constant SENSOR_ADDR.
REQ-012 write_val  out  8  CFG_VAL while mode=0, else 8'h00.
REQ-013 data_ready  in  1  master completion flag; rising edge = transaction done.
REQ-014 read_val  in  8  measurement, valid on data_ready rising edge.
REQ-015 rd_en  in  1  consumer pop strobe.
REQ-016 rd_data  out  8  FIFO head (first-word fall-through).
REQ-017 empty / full  out  1 each  FIFO status.
REQ-018 overflow  out  1  sticky, set when a sample is dropped; cleared by reset only.
REQ-019 timeout_err  out  1  sticky, set on transaction timeout; cleared by reset only.

Function
REQ-020 FSM states: IDLE, CFG, CFG_GAP, READ, STORE, SLEEP.
REQ-021 IDLE -> CFG when enable=1; CFG drives start=1, mode=0.
REQ-022 data_ready edge detect uses a registered copy; edge = data_ready & ~data_ready_q.
REQ-023 CFG -> CFG_GAP on edge; start deasserts the next cycle; CFG_GAP holds start=0 exactly 1 cycle, then -> READ.
REQ-024 READ drives start=1, mode=1; on edge capture read_val -> STORE.
REQ-025 STORE: push captured byte if not full (or if full and rd_en same cycle); otherwise drop and set overflow; -> SLEEP.
REQ-026 SLEEP: start=0 until poll counter reaches POLL_DIV-1 (counted from READ entry), then -> READ; if enable=0 -> IDLE.
REQ-027 Configuration is written only on IDLE->CFG; READ loops never rewrite it.
REQ-028 Watchdog counts cycles in CFG/READ; at TIMEOUT: start=0, timeout_err=1, -> IDLE (no push).
REQ-029 enable falling mid-transaction: current transaction completes (or times out); then IDLE.
REQ-030 FIFO: pointers width log2(DEPTH)+1, wrap modulo 2*DEPTH; pop on empty ignored; simultaneous push+pop when full keeps count constant.
REQ-031 Latency: data_ready edge to empty=0 (FIFO previously empty) = 3 clocks.

Reset
REQ-032 On reset_n low: state=IDLE, start=0, mode=0, write_val=8'h00, FIFO empty (empty=1, full=0, rd_data=8'h00), overflow=0, timeout_err=0, counters=0, data_ready_q=0.
REQ-033 Reset mid-transaction drops start immediately (asynchronous), no partial sample stored.

Structure
REQ-034 Shared package sensor_pkg holds state enum, mode encodings (MODE_WRITE=0, MODE_READ=1), default SENSOR_ADDR/CFG_VAL.
REQ-035 FIFO is sub-module sample_fifo (DEPTH, width 8); sequencer FSM, poll counter and watchdog stay in sensor_sequencer.

Verification
REQ-036 Bench pairs with Sensor_top plus slave model at 7'h70, measurement 8'hf0: enable=1 -> one write of 8'h92, then reads; rd_data=8'hf0 after first read.
REQ-037 Slave increments measurement per transaction, rd_en never asserted: after 4 reads full=1, fifth read sets overflow=1, FIFO holds f0..f3.
REQ-038 POLL_DIV=200: successive READ start rising edges exactly 200 clocks apart.
REQ-039 Slave disabled (en=0), TIMEOUT=500: start drops after 500 cycles in CFG, timeout_err=1, state IDLE.
REQ-040 enable dropped during READ: transaction completes, sample pushed, start stays 0 afterwards.
REQ-041 reset_n pulsed low mid-READ: start=0 asynchronously, empty=1; after release with enable=1 the CFG write repeats.
